// File: rtl/cache_fill_arbiter.sv
// Shares single-ported main memory between I/D miss fills and D-side write-through stores.
// Fixed priority store > D miss > I miss; a fill issues 8 pipelined reads and steers returns to the owner.
module cache_fill_arbiter #(
  parameter int MEM_LAT       = 4,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [2:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  localparam int LAST_IDX = WORDS_PER_BLK - 1;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t      state, stateNext;
  logic [3:0]  issueCnt;
  logic [2:0]  retCnt;
  logic        ownerD;
  logic [15:0] baseAddr;
  logic        issuing;
  logic        retAccept;
  logic        missGrant;

  assign issuing   = (state == FILL) && !issueCnt[3];
  assign retAccept = (state == FILL) && mem_rvalid;
  assign missGrant = (state == IDLE) && !d_wr_req && (d_miss || i_miss);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      issueCnt <= '0;
      retCnt   <= '0;
      ownerD   <= 1'b0;
    end else begin
      state <= stateNext;
      if (missGrant) ownerD <= d_miss;
      if (state == DONE) begin
        issueCnt <= '0;
        retCnt   <= '0;
      end else begin
        if (issuing)   issueCnt <= issueCnt + 4'd1;
        if (retAccept) retCnt   <= retCnt + 3'd1;
      end
      assert (MEM_LAT >= 1 && WORDS_PER_BLK == 8);
    end
  end

  // Block base is datapath only; it is always rewritten before a fill uses it.
  always_ff @(posedge clk) begin
    if (missGrant) baseAddr <= (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
  end

  always_comb begin
    stateNext   = state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    fill_idx    = '0;
    fill_data   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (d_wr_req)              stateNext = WRITE;
        else if (d_miss || i_miss) stateNext = FILL;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        stateNext = IDLE;
      end
      FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = baseAddr + {12'b0, issueCnt[2:0], 1'b0};
        end
        // Returns may overlap the issue phase; steer them straight to the owner.
        if (mem_rvalid) begin
          d_fill_we = ownerD;
          i_fill_we = !ownerD;
          fill_idx  = retCnt;
          fill_data = mem_rdata;
          if (retCnt == 3'(LAST_IDX)) stateNext = DONE;
        end
      end
      DONE: begin
        d_fill_done = ownerD;
        i_fill_done = !ownerD;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized bench for cache_fill_arbiter: a transaction-level schedule model predicts every output per cycle.
module tb_cache_fill_arbiter;

  localparam int LAT  = 4;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.MEM_LAT(LAT), .WORDS_PER_BLK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  // Pipelined memory: read data is addr + 0x1000, LAT cycles after issue; spur injects stray rvalids.
  logic [LAT-1:0] pipeV = '0;
  logic [15:0]    pipeD [LAT];
  logic           spur = 1'b0;
  logic [15:0]    spurData = '0;

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      pipeV[k] <= pipeV[k-1];
      pipeD[k] <= pipeD[k-1];
    end
    pipeV[0] <= (mem_en === 1'b1) && (mem_wr === 1'b0);
    pipeD[0] <= mem_addr + 16'h1000;
  end

  assign mem_rvalid = pipeV[LAT-1] | spur;
  assign mem_rdata  = pipeV[LAT-1] ? pipeD[LAT-1] : spurData;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        iWe;
    logic        dWe;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        iDone;
    logic        dDone;
    logic        ack;
    logic        busy;
  } outs_t;

  outs_t    expOut  [NCYC];
  bit [1:0] chkMode [NCYC];
  bit       fillWin [NCYC];
  bit       dropI   [NCYC];
  bit       dropD   [NCYC];
  bit       dropW   [NCYC];

  int cyc = 0;
  int freeAt = 0;
  int grantCyc = 0;
  bit lastFill = 0;
  bit fillOwnerD = 0;
  int nAsserts = 0;
  int nFail = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    if (obs !== expv) begin
      nFail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic schedStore(input int t, input logic [15:0] a, input logic [15:0] d);
    expOut[t+1].en    = 1'b1;
    expOut[t+1].wr    = 1'b1;
    expOut[t+1].addr  = a;
    expOut[t+1].wdata = d;
    expOut[t+1].ack   = 1'b1;
    expOut[t+1].busy  = 1'b1;
    freeAt   = t + 2;
    dropW[t+2] = 1'b1;
    lastFill = 1'b0;
  endtask

  task automatic schedFill(input int t, input bit ownD, input logic [15:0] a);
    logic [15:0] base;
    base = a & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      expOut[t+1+k].en   = 1'b1;
      expOut[t+1+k].addr = base + 16'(2 * k);
      expOut[t+1+k+LAT].iWe  = !ownD;
      expOut[t+1+k+LAT].dWe  = ownD;
      expOut[t+1+k+LAT].idx  = 3'(k);
      expOut[t+1+k+LAT].data = base + 16'(2 * k) + 16'h1000;
    end
    for (int j = t + 1; j <= t + 13; j++) expOut[j].busy = 1'b1;
    for (int j = t + 1; j <= t + 12; j++) fillWin[j] = 1'b1;
    expOut[t+13].iDone = !ownD;
    expOut[t+13].dDone = ownD;
    freeAt = t + 14;
    if (ownD) dropD[t+14] = 1'b1;
    else      dropI[t+14] = 1'b1;
    lastFill   = 1'b1;
    fillOwnerD = ownD;
    grantCyc   = t;
  endtask

  task automatic runCycle();
    outs_t o;
    if (rst_n && cyc >= freeAt) begin
      if (d_wr_req)    schedStore(cyc, d_wr_addr, d_wr_data);
      else if (d_miss) schedFill(cyc, 1'b1, d_miss_addr);
      else if (i_miss) schedFill(cyc, 1'b0, i_miss_addr);
    end
    @(negedge clk);
    o = expOut[cyc];
    if (chkMode[cyc] != 0) begin
      checkEq("mem_en", 32'(mem_en), 32'(o.en));
      if (o.en) begin
        checkEq("mem_wr", 32'(mem_wr), 32'(o.wr));
        checkEq("mem_addr", 32'(mem_addr), 32'(o.addr));
        if (o.wr) checkEq("mem_wdata", 32'(mem_wdata), 32'(o.wdata));
      end
      checkEq("i_fill_we", 32'(i_fill_we), 32'(o.iWe));
      checkEq("d_fill_we", 32'(d_fill_we), 32'(o.dWe));
      if (o.iWe || o.dWe) begin
        checkEq("fill_idx", 32'(fill_idx), 32'(o.idx));
        checkEq("fill_data", 32'(fill_data), 32'(o.data));
      end
      checkEq("i_fill_done", 32'(i_fill_done), 32'(o.iDone));
      checkEq("d_fill_done", 32'(d_fill_done), 32'(o.dDone));
      checkEq("d_wr_ack", 32'(d_wr_ack), 32'(o.ack));
      checkEq("busy", 32'(busy), 32'(o.busy));
    end
    if (chkMode[cyc] == 2) begin
      checkEq("rst_mem_wr", 32'(mem_wr), 32'd0);
      checkEq("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkEq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      checkEq("rst_fill_idx", 32'(fill_idx), 32'd0);
      checkEq("rst_fill_data", 32'(fill_data), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    spur = 1'b0;
    if (dropI[cyc]) i_miss   = 1'b0;
    if (dropD[cyc]) d_miss   = 1'b0;
    if (dropW[cyc]) d_wr_req = 1'b0;
  endtask

  task automatic doReset(input int n, input bit clearReqs);
    rst_n = 1'b0;
    for (int j = cyc + 1; j < NCYC; j++) begin
      expOut[j] = '0;
      fillWin[j] = 1'b0;
      dropI[j] = 1'b0;
      dropD[j] = 1'b0;
      dropW[j] = 1'b0;
    end
    for (int j = cyc + 1; j <= cyc + n; j++) chkMode[j] = 2'd2;
    freeAt   = cyc + 1;
    lastFill = 1'b0;
    if (clearReqs) begin
      i_miss = 1'b0;
      d_miss = 1'b0;
      d_wr_req = 1'b0;
    end
    repeat (n) runCycle();
    rst_n = 1'b1;
  endtask

  task automatic runUntilIdle();
    int guard;
    guard = 0;
    while (guard < 200 && (cyc <= freeAt || i_miss || d_miss || d_wr_req)) begin
      runCycle();
      guard++;
    end
    if (guard >= 200) checkEq("idle_bound", 32'(guard), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < NCYC; j++) begin
      expOut[j]  = '0;
      chkMode[j] = 2'd1;
      fillWin[j] = 1'b0;
      dropI[j] = 1'b0;
      dropD[j] = 1'b0;
      dropW[j] = 1'b0;
    end
    chkMode[0] = 2'd0;
    // Reset with all requests high, then priority order store > D fill > I fill
    d_wr_req = 1'b1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
    d_miss = 1'b1;   d_miss_addr = 16'h2010;
    i_miss = 1'b1;   i_miss_addr = 16'h0000;
    @(posedge clk);
    #1;
    doReset(2, 1'b0);
    runUntilIdle();

    // Plain I-miss fill from a mid-block address
    i_miss = 1'b1; i_miss_addr = 16'h0046;
    runUntilIdle();

    // Store raised during a fill waits for the fill to finish
    d_miss = 1'b1; d_miss_addr = 16'h7A3C;
    repeat (4) runCycle();
    d_wr_req = 1'b1; d_wr_addr = 16'h4001; d_wr_data = 16'h1234;
    runUntilIdle();

    // Requester abandons its miss two cycles in
    i_miss = 1'b1; i_miss_addr = 16'h1238;
    repeat (2) runCycle();
    i_miss = 1'b0;
    runUntilIdle();

    // Reset mid-fill, then a fresh D fill
    d_miss = 1'b1; d_miss_addr = 16'h5550;
    repeat (6) runCycle();
    doReset(10, 1'b1);
    d_miss = 1'b1; d_miss_addr = 16'h6668;
    runUntilIdle();

    // Random traffic with stray rvalids and occasional resets
    while (cyc < NCYC - 60) begin
      runCycle();
      if (!d_wr_req && $urandom_range(0, 9) == 0) begin
        d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      if (!d_miss && !(lastFill && cyc < freeAt && fillOwnerD) && $urandom_range(0, 7) == 0) begin
        d_miss = 1'b1; d_miss_addr = 16'($urandom);
      end
      if (!i_miss && !(lastFill && cyc < freeAt && !fillOwnerD) && $urandom_range(0, 7) == 0) begin
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
      end
      if (lastFill && cyc == grantCyc + 2 && $urandom_range(0, 2) == 0) begin
        if (fillOwnerD) d_miss = 1'b0;
        else            i_miss = 1'b0;
      end
      if (!fillWin[cyc] && $urandom_range(0, 3) == 0) begin
        spur = 1'b1; spurData = 16'($urandom);
      end
      if ($urandom_range(0, 499) == 0) doReset(10, 1'b1);
    end
    runUntilIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
